// File: rtl/fft_input_reorder_if.sv
// Sample-in / operand-pair-out bundle between the upstream source, the
// reorder stage and the FP16 adder.
interface fft_input_reorder_if #(
  parameter int unsigned DW = 16
);
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_ready;
  logic [DW-1:0] o_a;
  logic [DW-1:0] o_b;
  logic          o_valid;
  logic          o_last;
  logic          o_daz;

  // Upstream source / downstream consumer side.
  modport master (
    output i_valid, i_data,
    input  i_ready, o_a, o_b, o_valid, o_last, o_daz
  );

  // Reorder stage side.
  modport slave (
    input  i_valid, i_data,
    output i_ready, o_a, o_b, o_valid, o_last, o_daz
  );
endinterface

// File: rtl/fft_input_reorder.sv
// FFT input stage: gathers one frame of 2^LOG2N FP16 samples into
// bit-reversed order, flushing subnormals to signed zero, then streams the
// frame out as adjacent operand pairs, one pair per cycle.
module fft_input_reorder #(
  parameter int unsigned LOG2N = 4,
  parameter int unsigned DW    = 16
) (
  input logic               clk,
  input logic               rst,
  fft_input_reorder_if.slave bus
);

  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned RW = LOG2N - 1;

  typedef enum logic {StLoad, StDrain} state_e;

  state_e           state_q, state_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [RW-1:0]    rd_cnt_q, rd_cnt_d;

  logic [DW-1:0] mem [N];

  logic [DW-1:0] o_a_q, o_b_q;
  logic          o_valid_q, o_last_q, o_daz_q;

  logic          accept;
  logic          is_sub;
  logic [DW-1:0] wr_data;
  logic          last_wr;
  logic          last_rd;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Accept decode and subnormal flush; the adder assumes a hidden 1, so a
  // zero exponent with nonzero mantissa must become a signed zero.
  always_comb begin
    accept  = (state_q == StLoad) && bus.i_valid;
    is_sub  = (bus.i_data[14:10] == 5'd0) && (bus.i_data[9:0] != 10'd0);
    wr_data = is_sub ? {bus.i_data[DW-1], {(DW-1){1'b0}}} : bus.i_data;
    last_wr = (wr_cnt_q == {LOG2N{1'b1}});
    last_rd = (rd_cnt_q == {RW{1'b1}});
  end

  // Next-state logic: LOAD counts accepted samples, DRAIN counts issued pairs.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (last_wr) state_d = StDrain;
        end
      end
      StDrain: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (last_rd) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Frame store, written at the bit-reversed sample index; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[bitrev(wr_cnt_q)] <= wr_data;
    end
  end

  // Registered operand pair; o_a/o_b hold between frames, o_valid qualifies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_a_q     <= '0;
      o_b_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else if (state_q == StDrain) begin
      o_a_q     <= mem[{rd_cnt_q, 1'b0}];
      o_b_q     <= mem[{rd_cnt_q, 1'b1}];
      o_valid_q <= 1'b1;
      o_last_q  <= last_rd;
    end else begin
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end
  end

  // Sticky flush flag: restarts on sample 0, a flush on that same sample wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_daz_q <= 1'b0;
    end else if (accept) begin
      if (wr_cnt_q == '0) begin
        o_daz_q <= is_sub;
      end else if (is_sub) begin
        o_daz_q <= 1'b1;
      end
    end
  end

  assign bus.i_ready = (state_q == StLoad);
  assign bus.o_a     = o_a_q;
  assign bus.o_b     = o_b_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_last  = o_last_q;
  assign bus.o_daz   = o_daz_q;

endmodule

// File: tb/tb_fft_input_reorder.sv
// Randomised scoreboard bench for fft_input_reorder: a frame-level model
// predicts the pair stream; a negedge monitor compares every cycle.
module tb_fft_input_reorder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_input_reorder_if #(.DW(16)) bus ();

  fft_input_reorder #(.LOG2N(4), .DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    logic        daz;
  } pair_t;

  pair_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [15:0] m_samples [16];
  int          m_cnt    = 0;
  bit          m_drain  = 0;
  int          m_left   = 0;
  bit          m_ovalid = 0;
  bit          m_daz    = 0;

  logic [15:0] fr [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int brev4(input int n);
    int r = 0;
    for (int b = 0; b < 4; b++) if (((n >> b) & 1) != 0) r += 1 << (3 - b);
    return r;
  endfunction

  function automatic bit is_subn(input logic [15:0] d);
    return (d[14:10] == 5'd0) && (d[9:0] != 10'd0);
  endfunction

  function automatic logic [15:0] flushed(input logic [15:0] d);
    return is_subn(d) ? {d[15], 15'd0} : d;
  endfunction

  // Frame-level model: the k-th output pair is (x[brev(2k)], x[brev(2k+1)]).
  task automatic push_frame();
    pair_t p;
    for (int k = 0; k < 8; k++) begin
      p.a    = flushed(m_samples[brev4(2 * k)]);
      p.b    = flushed(m_samples[brev4(2 * k + 1)]);
      p.last = (k == 7);
      p.daz  = m_daz;
      exp_q.push_back(p);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_drain = 0; m_left = 0; m_ovalid = 0; m_daz = 0;
        exp_q.delete();
      end else if (m_drain) begin
        m_ovalid = 1;
        m_left--;
        if (m_left == 0) m_drain = 0;
      end else begin
        m_ovalid = 0;
        if (bus.i_valid) begin
          if (m_cnt == 0) m_daz = is_subn(bus.i_data);
          else if (is_subn(bus.i_data)) m_daz = 1;
          m_samples[m_cnt] = bus.i_data;
          m_cnt++;
          if (m_cnt == 16) begin
            push_frame();
            m_cnt = 0; m_drain = 1; m_left = 8;
          end
        end
      end
    end
  end

  // Monitor: handshake/flag checks every cycle, pair compare on o_valid.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("i_ready", bus.i_ready, !m_drain);
        chk("o_valid", bus.o_valid, m_ovalid);
        chk("o_daz", bus.o_daz, m_daz);
        if (bus.o_valid) begin
          chk("pair_avail", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("o_a", bus.o_a, e.a);
            chk("o_b", bus.o_b, e.b);
            chk("o_last", bus.o_last, e.last);
            chk("pair_daz", bus.o_daz, e.daz);
          end
        end else begin
          chk("o_last_idle", bus.o_last, 0);
        end
      end
    end
  end

  // Drives fr[]; optional idle cycle after each sample and junk during drain.
  task automatic send_frame(input bit gaps, input bit junk);
    for (int n = 0; n < 16; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = fr[n];
      @(posedge clk); #1;
      if (gaps && n != 15) begin
        bus.i_valid = 1'b0;
        bus.i_data  = 16'($urandom);
        @(posedge clk); #1;
      end
    end
    bus.i_valid = 1'b0;
    begin
      int t = 0;
      while (m_drain && t < 20) begin
        bus.i_valid = junk;
        bus.i_data  = 16'($urandom);
        @(posedge clk); #1;
        t++;
      end
    end
    bus.i_valid = 1'b0;
    chk("drain_done", m_drain, 0);
  endtask

  task automatic ordering_frame();
    for (int n = 0; n < 16; n++) fr[n] = 16'h3C00 + 16'(n);
  endtask

  task automatic random_frame();
    for (int n = 0; n < 16; n++) begin
      fr[n] = 16'($urandom);
      if ($urandom_range(0, 3) == 0) fr[n][14:10] = 5'd0;
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_i_ready", bus.i_ready, 1);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_a", bus.o_a, 0);
    chk("rst_o_b", bus.o_b, 0);
    chk("rst_o_last", bus.o_last, 0);
    chk("rst_o_daz", bus.o_daz, 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Ordering.
    ordering_frame();
    send_frame(0, 0);
    // Subnormal flush.
    ordering_frame();
    fr[1] = 16'h8001;
    fr[2] = 16'h0200;
    send_frame(0, 0);
    // Clean frame: o_daz falls on sample 0.
    ordering_frame();
    send_frame(0, 0);
    // Special values.
    ordering_frame();
    fr[0] = 16'h7C00;
    fr[8] = 16'h7E00;
    fr[4] = 16'hFC00;
    send_frame(0, 0);
    // Gapped input, junk held during drain.
    ordering_frame();
    send_frame(1, 1);

    // Asynchronous reset after five accepted samples.
    for (int n = 0; n < 5; n++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = 16'h4000 + 16'(n);
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_o_a", bus.o_a, 0);
    chk("arst_o_b", bus.o_b, 0);
    chk("arst_o_valid", bus.o_valid, 0);
    chk("arst_i_ready", bus.i_ready, 1);
    chk("arst_o_daz", bus.o_daz, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    ordering_frame();
    send_frame(0, 0);

    // Back-to-back and random frames.
    for (int r = 0; r < 5; r++) begin
      random_frame();
      send_frame(r == 3, r == 2);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
